uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

- Round-robin arbiter sharing the single UART transmit write port (wr_uart / wr_data / tx_full of the UART core) among N_REQ byte-stream requesters, e.g. CPU MMIO path, debug printf unit, DMA log engine.
- Grants one requester at a time and holds the grant for a whole message, bounded by MAX_BURST bytes.
- Sits between the requesters and the UART core in the I/O subsystem.

## Interface
- N_REQ, 4, number of requesters (2..8)
- MAX_BURST, 16, max bytes written per grant before forced release (1..255)
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- req  in  N_REQ  per-requester "byte available"; must hold with stable data until ack
- data  in  8*N_REQ  per-requester byte; requester i on data[8*i+7:8*i]
- last  in  N_REQ  byte on data[i] is the final byte of the message; qualified by req[i]
- ack  out  N_REQ  one-hot; byte from requester i accepted this cycle
- grant  out  N_REQ  one-hot registered grant, or all zero
- busy  out  1  grant held (state GRANT)
- wr_uart  out  1  write strobe to UART TX FIFO
- wr_data  out  8  byte to UART TX FIFO
- tx_full  in  1  UART TX FIFO full

## Operation
- States: IDLE, GRANT. Registers: state, grant (one-hot), ptr (log2 N_REQ, round-robin start), cnt (8 bit, bytes written this grant).
- IDLE: if req != 0, pick the first set req[i] scanning i = ptr, ptr+1, … mod N_REQ. Register grant = 1<<i, cnt = 0, go to GRANT. If req == 0, stay.
- GRANT (requester g):
  - Accept when req[g] & ~tx_full: wr_uart = 1, wr_data = data[g], ack[g] = 1, all combinational in the same cycle; cnt increments.
  - Release on an accepted byte with last[g] = 1, or with cnt == MAX_BURST-1.
  - Release when req[g] = 0 (abandon); no byte is written that cycle.
  - On release: grant = 0, ptr = (g+1) mod N_REQ, state = IDLE.
- tx_full = 1 in GRANT: no write, no ack, grant held indefinitely. No timeout.
- Non-granted requesters never receive ack. Their req is ignored until arbitration.
- wr_data = 8'h00 whenever wr_uart = 0.
- Forced release at MAX_BURST: the requester keeps req high and waits for its next turn. Its message continues in order. Other requesters may interleave between bursts.

## Timing
- Reset values: state IDLE, grant 0, ptr 0, cnt 0. Outputs ack 0, busy 0, wr_uart 0, wr_data 0.
- Arbitration latency: req rising in IDLE at cycle t gives grant/busy at t+1. The earliest first write is at t+1.
- Throughput while granted: 1 byte/cycle when tx_full = 0.
- Release costs one IDLE cycle: minimum 1 bubble between grants, even back-to-back.
- ack/wr_uart are Mealy outputs of registered grant plus live req/tx_full. There is no registered data path, so there is zero added byte latency.
- Simultaneous req in IDLE: lowest index at or above ptr (wrapping) wins.
- Asserting reset mid-grant: grant drops immediately. A byte presented in that cycle is neither acked nor written.
- MAX_BURST = 1: every accepted byte releases, giving strict byte-level round robin.

## Structure
- Shared package uart_pkg:
  - state encoding localparams (IDLE = 0, GRANT = 1)
  - default N_REQ / MAX_BURST constants
- Sub-module uart_rr_pick: combinational rotating-priority picker (req, ptr → one-hot pick, valid).
- Top block holds the FSM, ptr/cnt registers and the output muxing.

## Test plan
- Single requester 0 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43), tx_full = 0:
  - grant = 0001 one cycle after req
  - wr_uart high 3 consecutive cycles with those bytes
  - ack[0] each cycle; then IDLE, ptr = 1
- Requesters 0 and 2 request simultaneously, ptr = 0, 1-byte messages each:
  - requester 0 written first, one IDLE bubble, then requester 2
  - ptr ends at 3
- MAX_BURST = 4; requester 1 streams 6 bytes with requester 3 also pending:
  - bytes 0..3 from req 1, then a bubble
  - one message from req 3, then the remaining 2 bytes from req 1
- tx_full held high 5 cycles mid-message:
  - no wr_uart, no ack, grant stable
  - writing resumes the cycle tx_full falls, data unchanged
- Granted requester drops req without last:
  - release next cycle, no write
  - another pending requester granted after the bubble
- Assert rst while in GRANT with a byte pending:
  - all outputs 0 during reset, no write
  - after deassert, arbitration restarts from ptr 0

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter.
// State encoding and default sizing.
package uart_pkg;

  typedef logic state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t GRANT = 1'b1;

  localparam int N_REQ_DEF     = 4;
  localparam int MAX_BURST_DEF = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set req at or after ptr.
// Purely combinational; pick is one-hot or zero.
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  logic [PW-1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX write port.
// Grant is held per message, capped at MAX_BURST bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  input  logic [N_REQ-1:0]   last,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               wr_uart,
  output logic [7:0]         wr_data,
  input  logic               tx_full
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t            state;
  state_t            state_nx;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_nx;
  logic [7:0]        cnt;
  logic [N_REQ-1:0]  pick;
  logic              pick_valid;
  logic [PW-1:0]     g_idx;
  logic              g_req;
  logic              g_last;
  logic [7:0]        g_data;
  logic              accept;
  logic              rel;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Decode the held grant into index, request, last flag and byte.
  always_comb begin
    g_idx  = '0;
    g_req  = 1'b0;
    g_last = 1'b0;
    g_data = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        g_idx  = PW'(i);
        g_req  = req[i];
        g_last = last[i];
        g_data = data[8*i +: 8];
      end
    end
  end

  assign ptr_nx = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_valid) state_nx = GRANT;
      GRANT:   if (rel)        state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant <= pick;
            cnt   <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            grant <= '0;
            ptr   <= ptr_nx;
            cnt   <= '0;
          end else if (accept) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: grant <= '0;
      endcase
    end
  end

  // Mealy outputs: registered grant qualified by live req/tx_full.
  always_comb begin
    busy    = (state == GRANT);
    accept  = busy && g_req && !tx_full;
    rel     = busy && (!g_req ||
              (accept && (g_last || cnt == 8'(MAX_BURST - 1))));
    wr_uart = accept;
    wr_data = accept ? g_data : 8'h00;
    ack     = accept ? grant : '0;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, MAX_BURST=4).
// Byte sources per requester; expectations written per cycle.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  last;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        busy;
  logic        wr_uart;
  logic [7:0]  wr_data;
  logic        tx_full;

  int nchk = 0;
  int nerr = 0;

  logic [7:0] mem [4][8];
  bit         lst [4][8];
  int         pos [4];
  int         len [4];
  bit         en  [4];

  uart_tx_arbiter #(
    .N_REQ     (4),
    .MAX_BURST (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data    (data),
    .last    (last),
    .ack     (ack),
    .grant   (grant),
    .busy    (busy),
    .wr_uart (wr_uart),
    .wr_data (wr_data),
    .tx_full (tx_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] r;
      logic [2:0] p;
      bit         on;
      r  = i[1:0];
      p  = pos[r][2:0];
      on = en[r] && (pos[r] < len[r]);
      req[i]          = on;
      data[8*i +: 8]  = on ? mem[r][p] : 8'h00;
      last[i]         = on && lst[r][p];
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      pos[i[1:0]] = 0;
      len[i[1:0]] = 0;
      en[i[1:0]]  = 1'b1;
    end
  endtask

  task automatic add(input int i, input logic [7:0] b, input bit l);
    logic [1:0] r;
    r = i[1:0];
    mem[r][len[r][2:0]] = b;
    lst[r][len[r][2:0]] = l;
    len[r]++;
  endtask

  // One clock cycle: check the combinational outputs, then advance.
  task automatic cyc(input string tag, input logic wr, input logic [7:0] d,
                     input logic [3:0] a, input logic [3:0] g);
    logic [3:0] lat;
    drive();
    #1;
    chk({tag, "_wr"},    32'(wr_uart), 32'(wr));
    chk({tag, "_data"},  32'(wr_data), 32'(d));
    chk({tag, "_ack"},   32'(ack),     32'(a));
    chk({tag, "_grant"}, 32'(grant),   32'(g));
    chk({tag, "_busy"},  32'(busy),    32'(g != 4'b0));
    lat = ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (lat[i]) pos[i[1:0]]++;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    tx_full = 1'b0;
    clr();
    drive();
    #2;
    chk("rst_grant", 32'(grant),   32'h0);
    chk("rst_busy",  32'(busy),    32'h0);
    chk("rst_wr",    32'(wr_uart), 32'h0);
    chk("rst_data",  32'(wr_data), 32'h0);
    chk("rst_ack",   32'(ack),     32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single requester, three-byte message.
    add(0, 8'h41, 0); add(0, 8'h42, 0); add(0, 8'h43, 1);
    cyc("t1_arb", 0, 8'h00, 4'b0000, 4'b0000);
    cyc("t1_b0",  1, 8'h41, 4'b0001, 4'b0001);
    cyc("t1_b1",  1, 8'h42, 4'b0001, 4'b0001);
    cyc("t1_b2",  1, 8'h43, 4'b0001, 4'b0001);
    chk("t1_ptr", 32'(dut.ptr), 32'd1);
    cyc("t1_idle", 0, 8'h00, 4'b0000, 4'b0000);

    // Simultaneous requests from 0 and 2.
    do_reset();
    add(0, 8'hA0, 1); add(2, 8'hA2, 1);
    cyc("t2_arb",    0, 8'h00, 4'b0000, 4'b0000);
    cyc("t2_r0",     1, 8'hA0, 4'b0001, 4'b0001);
    cyc("t2_bubble", 0, 8'h00, 4'b0000, 4'b0000);
    cyc("t2_r2",     1, 8'hA2, 4'b0100, 4'b0100);
    chk("t2_ptr", 32'(dut.ptr), 32'd3);

    // Burst cap of 4 with requester 3 interleaving.
    do_reset();
    for (int b = 0; b < 6; b++) add(1, 8'hB0 + 8'(b), b == 5);
    add(3, 8'hC3, 1);
    cyc("t3_arb", 0, 8'h00, 4'b0000, 4'b0000);
    cyc("t3_b0",  1, 8'hB0, 4'b0010, 4'b0010);
    cyc("t3_b1",  1, 8'hB1, 4'b0010, 4'b0010);
    cyc("t3_b2",  1, 8'hB2, 4'b0010, 4'b0010);
    cyc("t3_b3",  1, 8'hB3, 4'b0010, 4'b0010);
    cyc("t3_bub1", 0, 8'h00, 4'b0000, 4'b0000);
    cyc("t3_c3",  1, 8'hC3, 4'b1000, 4'b1000);
    cyc("t3_bub2", 0, 8'h00, 4'b0000, 4'b0000);
    cyc("t3_b4",  1, 8'hB4, 4'b0010, 4'b0010);
    cyc("t3_b5",  1, 8'hB5, 4'b0010, 4'b0010);
    chk("t3_ptr", 32'(dut.ptr), 32'd2);

    // tx_full stalls mid-message.
    clr();
    add(2, 8'hD0, 0); add(2, 8'hD1, 0); add(2, 8'hD2, 1);
    cyc("t4_arb", 0, 8'h00, 4'b0000, 4'b0000);
    cyc("t4_d0",  1, 8'hD0, 4'b0100, 4'b0100);
    tx_full = 1'b1;
    for (int s = 0; s < 5; s++)
      cyc("t4_full", 0, 8'h00, 4'b0000, 4'b0100);
    tx_full = 1'b0;
    cyc("t4_d1",  1, 8'hD1, 4'b0100, 4'b0100);
    cyc("t4_d2",  1, 8'hD2, 4'b0100, 4'b0100);
    chk("t4_ptr", 32'(dut.ptr), 32'd3);

    // Granted requester abandons its message.
    clr();
    add(3, 8'hE0, 0); add(3, 8'hE1, 0); add(3, 8'hE2, 0);
    add(0, 8'hF0, 1);
    cyc("t5_arb", 0, 8'h00, 4'b0000, 4'b0000);
    cyc("t5_e0",  1, 8'hE0, 4'b1000, 4'b1000);
    en[3] = 1'b0;
    cyc("t5_drop",   0, 8'h00, 4'b0000, 4'b1000);
    cyc("t5_bubble", 0, 8'h00, 4'b0000, 4'b0000);
    cyc("t5_f0",  1, 8'hF0, 4'b0001, 4'b0001);
    chk("t5_ptr", 32'(dut.ptr), 32'd1);

    // Reset while granted with a byte pending.
    clr();
    add(1, 8'h60, 0); add(1, 8'h61, 1);
    cyc("t6_arb", 0, 8'h00, 4'b0000, 4'b0000);
    chk("t6_pre_grant", 32'(grant), 32'h2);
    rst = 1'b1;
    add(0, 8'h70, 1);
    drive();
    #1;
    chk("t6_rst_grant", 32'(grant),   32'h0);
    chk("t6_rst_wr",    32'(wr_uart), 32'h0);
    chk("t6_rst_ack",   32'(ack),     32'h0);
    chk("t6_rst_data",  32'(wr_data), 32'h0);
    chk("t6_rst_busy",  32'(busy),    32'h0);
    @(posedge clk);
    #1;
    chk("t6_rst_wr2",   32'(wr_uart), 32'h0);
    rst = 1'b0;
    chk("t6_ptr0", 32'(dut.ptr), 32'd0);
    cyc("t6_arb2", 0, 8'h00, 4'b0000, 4'b0000);
    cyc("t6_h0",   1, 8'h70, 4'b0001, 4'b0001);
    cyc("t6_bub",  0, 8'h00, 4'b0000, 4'b0000);
    cyc("t6_g0",   1, 8'h60, 4'b0010, 4'b0010);
    cyc("t6_g1",   1, 8'h61, 4'b0010, 4'b0010);
    chk("t6_ptr", 32'(dut.ptr), 32'd2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
